// File: rtl/cpu_pkg.sv
// Shared definitions for the stack CPU and its memory-side helpers.
// Holds default widths, the opcode map and the dump reader state type.
package cpu_pkg;

  localparam int CPU_ADDR_W = 8;
  localparam int CPU_DATA_W = 8;

  localparam logic [3:0] OP_PUSHC = 4'b0000;
  localparam logic [3:0] OP_PUSHM = 4'b0001;
  localparam logic [3:0] OP_POP   = 4'b0010;
  localparam logic [3:0] OP_HALT  = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0110;
  localparam logic [3:0] OP_SUB   = 4'b0111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } dump_state_e;

endpackage

// File: rtl/dump_fifo.sv
// Small synchronous FIFO holding {addr, data} words waiting for the consumer.
// The head reads as zero while empty so the outputs are clean in and after reset.
module dump_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_occupancy,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_occupancy = r_count;
  assign o_head      = o_empty ? '0 : r_mem[r_rd_ptr];

  // A pop frees the slot in the same cycle, so push-while-full is fine when popping.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= nextPtr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= nextPtr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(i_push && o_full && !i_pop));

endmodule

// File: rtl/mem_dump_reader.sv
// Streams a window of CPU memory out as (address, data) pairs over valid/ready.
// Reads are throttled so issued-but-unconsumed words never exceed the buffer depth.
module mem_dump_reader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  dump_state_e r_state;
  dump_state_e w_next_state;

  logic [ADDR_W-1:0]        r_rd_ptr;
  logic [ADDR_W-1:0]        r_tag_addr;
  logic [ADDR_W:0]          r_length;
  logic [ADDR_W:0]          r_issued;
  logic                     r_inflight;
  logic                     r_done;
  logic                     w_done_next;
  logic                     w_accept;
  logic                     w_issue;
  logic                     w_last_issue;
  logic                     w_room;
  logic                     w_pop;
  logic [CNT_W-1:0]         w_occupancy;
  logic                     w_empty;
  logic                     w_full;
  logic [ADDR_W+DATA_W-1:0] w_head;

  // Ignore start in the done cycle so a back-to-back request cannot slip in.
  assign w_accept     = start && (r_state == IDLE) && !r_done;
  assign w_room       = ({1'b0, w_occupancy} + (CNT_W + 1)'(r_inflight)) < (CNT_W + 1)'(DEPTH);
  assign w_issue      = (r_state == RUN) && (r_issued < r_length) && w_room && !w_full;
  assign w_last_issue = ((r_issued + 1'b1) == r_length);
  assign w_pop        = !w_empty && out_ready;

  always_comb begin
    w_next_state = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (length != '0) w_next_state = RUN;
          else              w_done_next  = 1'b1;
        end
      end
      RUN: begin
        if (w_issue && w_last_issue) w_next_state = DRAIN;
      end
      DRAIN: begin
        if (!r_inflight && (w_occupancy == CNT_W'(1)) && w_pop) begin
          w_next_state = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_done     <= 1'b0;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_tag_addr <= '0;
      r_length   <= '0;
      r_issued   <= '0;
    end else begin
      r_state    <= w_next_state;
      r_done     <= w_done_next;
      r_inflight <= w_issue;
      if (w_accept) begin
        r_rd_ptr <= start_addr;
        r_length <= length;
        r_issued <= '0;
      end else if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_issued <= r_issued + 1'b1;
      end
      if (w_issue) r_tag_addr <= r_rd_ptr;
    end
  end

  dump_fifo #(
    .WIDTH(ADDR_W + DATA_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_inflight),
    .i_data     ({r_tag_addr, mem_rd_data}),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_occupancy(w_occupancy),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = r_rd_ptr;
  assign out_valid   = !w_empty;
  assign out_addr    = w_head[ADDR_W+DATA_W-1:DATA_W];
  assign out_data    = w_head[DATA_W-1:0];

endmodule
